ysyx_24110006_mdu: RTL and testbench
====================================

// Module: ysyx_24110006_mdu
// PURPOSE
//  Iterative RV32M multiply/divide unit beside the single-cycle ALU in EXU.
//  Takes an op plus two XLEN operands over a valid/ready handshake and computes over several cycles.
//  Holds the result until EXU accepts it.
//  Covers MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU; flushable on redirect.
// PARAMETERS
//  XLEN  32  operand/result width; even, >=8
// PORTS
//  clock      in   1     system clock
//  reset      in   1     synchronous, active-high reset
//  i_flush    in   1     kill in-flight op (branch/exception redirect)
//  i_valid    in   1     request valid
//  o_ready    out  1     unit idle, request accepted when i_valid&o_ready
//  i_op       in   3     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  i_a        in   XLEN  rs1 operand
//  i_b        in   XLEN  rs2 operand
//  o_valid    out  1     result valid
//  i_ready    in   1     consumer takes result when o_valid&i_ready
//  o_r        out  XLEN  result
//  o_busy     out  1     state!=IDLE
// BEHAVIOUR
//  Reset (sync, active-high): state IDLE, o_valid=0, o_r=0, counter=0; o_ready=1 next cycle.
//  FSM IDLE -> CALC -> DONE -> IDLE.
//  - IDLE: o_ready=1. On accept, latch op/operands.
//    Special cases go straight to DONE: div-by-zero, signed overflow, fast mul.
//    All other ops go to CALC with counter=XLEN.
//  - CALC: one radix-2 step per cycle; counter decrements; at counter==1 step -> DONE.
//  - DONE: o_valid=1, o_r stable; on i_ready -> IDLE (o_valid drops next cycle).
//    No back-to-back accept in the same cycle as result handoff.
//  Latency, accept edge -> o_valid high:
//  - normal ops: XLEN+1 cycles;
//  - special cases: 1 cycle.
//  Multiply: shift-add on |a|,|b| magnitudes with a 2*XLEN product.
//  - Sign handling: MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned.
//  - Negate the product when the sign bits differ.
//  - MUL returns low XLEN bits; MULH* return high XLEN bits.
//  Divide: restoring, on magnitudes.
//  - Quotient sign = sa^sb; remainder sign = sign of dividend.
//  Boundaries:
//  - b==0: DIV/DIVU q=all-ones; REM/REMU r=a.
//  - DIV/REM with a==MIN, b==-1: q=MIN, r=0.
//  - MULHU with all-ones x all-ones: high = all-ones minus 1 (0xFFFFFFFE at XLEN=32).
//  Flush: priority below reset, above everything else.
//  - Next state IDLE, o_valid=0; partial/held result discarded.
//  - i_valid in a flush cycle is not accepted.
//  Operands change while busy: ignored (latched copies used).
//  i_ready without o_valid: ignored.
// CONFIGURATION
//  YSYX_24110006_MDU_FAST_MUL_EN:
//  - defined: MUL* computed by a single XLEN x XLEN combinational multiplier, 1-cycle latency.
//    Divide is unchanged.
//  - undefined: MUL* use the iterative path, XLEN+1 latency. No multiplier cell inferred.
// TESTING
//  1 MUL a=7,b=-3 (0xFFFFFFFD) -> o_r=0xFFFFFFEB after 33 cycles (1 with FAST_MUL).
//  2 MULH a=0x80000000,b=0x80000000 -> 0x40000000.
//    MULHSU a=-1,b=0xFFFFFFFF -> 0xFFFFFFFF.
//    MULHU a=0xFFFFFFFF,b=0xFFFFFFFF -> 0xFFFFFFFE.
//  3 DIV -7/2 -> -3 (0xFFFFFFFD); REM -7,2 -> -1; DIVU 100/7 -> 14; REMU 100,7 -> 2.
//  4 DIV by 0 -> 0xFFFFFFFF and REM a=5,b=0 -> 5, both 1-cycle;
//    DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
//  5 Backpressure: hold i_ready=0 for 10 cycles in DONE -> o_r stable, o_ready=0.
//    Then i_ready=1 -> o_valid=0 and o_ready=1 next cycle.
//  6 Accept DIVU, flush at cycle 10 -> o_valid never rises, o_ready=1 next cycle.
//    New DIVU 9/3 -> 3. Reset mid-CALC gives the same recovery.

Source files
------------

// File: rtl/ysyx_24110006_mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, valid/ready on both sides.
// Define YSYX_24110006_MDU_FAST_MUL_EN to compute MUL* with a single-cycle combinational multiplier.
module ysyx_24110006_mdu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_r,
  output logic            o_busy
);

  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d, sa_q, sa_d;
  logic [XLEN-1:0]   mag_q, mag_d, r_q, r_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              accept, sgn_a, sgn_b, sa, sb, div_zero, div_ovf;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] step;

  // Negation is applied to the full double-width product so MULH* high halves come out right.
  function automatic logic [XLEN-1:0] fmt(input logic [2:0] op, input logic neg, input logic sgn_a_in,
                                          input logic [2*XLEN-1:0] acc);
    logic [2*XLEN-1:0] p;
    p = neg ? -acc : acc;
    if (!op[2]) return (op[1:0] == 2'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    else if (!op[1]) return neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    else return sgn_a_in ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  endfunction

  always_comb begin
    accept   = i_valid && (state_q == S_IDLE) && !i_flush;
    sgn_a    = (i_op == 3'd1) || (i_op == 3'd2) || (i_op == 3'd4) || (i_op == 3'd6);
    sgn_b    = (i_op == 3'd1) || (i_op == 3'd4) || (i_op == 3'd6);
    sa       = sgn_a && i_a[XLEN-1];
    sb       = sgn_b && i_b[XLEN-1];
    mag_a    = sa ? -i_a : i_a;
    mag_b    = sb ? -i_b : i_b;
    div_zero = i_op[2] && (i_b == '0);
    div_ovf  = ((i_op == 3'd4) || (i_op == 3'd6)) && (i_a == MIN) && (i_b == '1);
  end

  // acc holds {partial_hi, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_sh - {1'b0, mag_q};
    div_ge   = !div_diff[XLEN];
    step     = op_q[2] ? {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge}
                       : {mul_sum, acc_q[XLEN-1:1]};
  end

`ifdef YSYX_24110006_MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    sa_d    = sa_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = i_op;
          neg_d = sa ^ sb;
          sa_d  = sa;
          if (div_zero) begin
            r_d     = i_op[1] ? i_a : '1;
            state_d = S_DONE;
          end else if (div_ovf) begin
            r_d     = i_op[1] ? '0 : MIN;
            state_d = S_DONE;
          end
`ifdef YSYX_24110006_MDU_FAST_MUL_EN
          else if (!i_op[2]) begin
            r_d     = fmt(i_op, sa ^ sb, sa, fast_prod);
            state_d = S_DONE;
          end
`endif
          else begin
            mag_d   = i_op[2] ? mag_b : mag_a;
            acc_d   = {{XLEN{1'b0}}, (i_op[2] ? mag_a : mag_b)};
            cnt_d   = CW'(XLEN);
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          r_d     = fmt(op_q, neg_q, sa_q, step);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (i_flush) state_d = S_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
      mag_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      sa_q    <= sa_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
    end
  end

  assign o_ready = (state_q == S_IDLE);
  assign o_valid = (state_q == S_DONE);
  assign o_busy  = (state_q != S_IDLE);
  assign o_r     = r_q;

endmodule

// File: tb/tb_ysyx_24110006_mdu.sv
// Scoreboard bench for ysyx_24110006_mdu: directed vectors, result and latency checked by a monitor.
module tb_ysyx_24110006_mdu;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
`ifdef YSYX_24110006_MDU_FAST_MUL_EN
  localparam int LMUL = 1;
`else
  localparam int LMUL = 33;
`endif
  localparam int LDIV = 33;

  logic        clock = 1'b0;
  logic        reset, i_flush, i_valid, o_ready, o_valid, i_ready, o_busy;
  logic [2:0]  i_op;
  logic [31:0] i_a, i_b, o_r;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int txn_id = 0;

  typedef struct {
    logic [31:0] r;
    int          lat;
    int          acc_cyc;
    int          id;
  } exp_t;
  exp_t sb_q[$];

  ysyx_24110006_mdu #(.XLEN(32)) dut (
    .clock  (clock),
    .reset  (reset),
    .i_flush(i_flush),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_op   (i_op),
    .i_a    (i_a),
    .i_b    (i_b),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_r    (o_r),
    .o_busy (o_busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%h required=%h", nm, act, req);
    end
  endtask

  // Drives one request; when expect_it is set the expected result is queued at the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input int lat, input bit expect_it);
    exp_t e;
    int   guard;
    @(negedge clock);
    i_op = op; i_a = a; i_b = b; i_valid = 1'b1;
    guard = 0;
    while (!o_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout got o_ready=%b required 1", o_ready);
      i_valid = 1'b0;
      return;
    end
    if (expect_it) begin
      e.r = r; e.lat = lat; e.acc_cyc = cyc + 1; e.id = txn_id;
      sb_q.push_back(e);
    end
    txn_id++;
    @(posedge clock);
    #1;
    i_valid = 1'b0;
    i_a = 32'hDEADBEEF;
    i_b = 32'h12345678;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb_q.size() != 0 || o_valid) && guard < 500) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 500) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got pending=%0d required 0", sb_q.size());
    end
  endtask

  initial begin : monitor
    exp_t e;
    bit   seen;
    seen = 1'b0;
    forever begin
      @(negedge clock);
      if (reset || !o_valid) begin
        seen = 1'b0;
      end else if (!seen) begin
        seen = 1'b1;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid got o_r=%h required no result", o_r);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("txn%0d_result", e.id), o_r, e.r);
          chk($sformatf("txn%0d_latency", e.id), 32'(cyc - e.acc_cyc + 1), 32'(e.lat));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    failures++;
    $display("FAIL watchdog got timeout required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stimulus
    int guard;
    reset = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_op = '0; i_a = '0; i_b = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("reset_o_ready", 32'(o_ready), 32'd1);
    chk("reset_o_valid", 32'(o_valid), 32'd0);
    chk("reset_o_r",     o_r,          32'h0);
    chk("reset_o_busy",  32'(o_busy),  32'd0);

    issue(OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LMUL, 1'b1);
    issue(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, LMUL, 1'b1);
    issue(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LMUL, 1'b1);
    issue(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LMUL, 1'b1);
    issue(OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LDIV, 1'b1);
    issue(OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LDIV, 1'b1);
    issue(OP_DIVU,   32'd100,      32'd7,        32'd14,       LDIV, 1'b1);
    issue(OP_REMU,   32'd100,      32'd7,        32'd2,        LDIV, 1'b1);
    issue(OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1,    1'b1);
    issue(OP_REM,    32'd5,        32'd0,        32'd5,        1,    1'b1);
    issue(OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1,    1'b1);
    issue(OP_REMU,   32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 1,    1'b1);
    issue(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,    1'b1);
    issue(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0,        1,    1'b1);
    drain();

    // Backpressure: result must hold while the consumer stalls.
    i_ready = 1'b0;
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14, LDIV, 1'b1);
    guard = 0;
    while (!o_valid && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("bp_hold%0d_o_r", k),     o_r,          32'd14);
      chk($sformatf("bp_hold%0d_o_ready", k), 32'(o_ready), 32'd0);
      @(negedge clock);
    end
    i_ready = 1'b1;
    @(negedge clock);
    chk("bp_release_o_valid", 32'(o_valid), 32'd0);
    chk("bp_release_o_ready", 32'(o_ready), 32'd1);

    // Flush mid-divide; a request presented in the flush cycle must be dropped.
    issue(OP_DIVU, 32'd1000, 32'd3, 32'd0, 0, 1'b0);
    repeat (9) @(negedge clock);
    i_flush = 1'b1;
    i_valid = 1'b1; i_op = OP_DIVU; i_a = 32'd9; i_b = 32'd3;
    @(negedge clock);
    i_flush = 1'b0;
    i_valid = 1'b0;
    chk("flush_o_valid", 32'(o_valid), 32'd0);
    chk("flush_o_ready", 32'(o_ready), 32'd1);
    chk("flush_o_busy",  32'(o_busy),  32'd0);
    repeat (40) @(negedge clock);
    chk("flush_quiet_o_valid", 32'(o_valid), 32'd0);

    // Reset mid-divide.
    issue(OP_DIVU, 32'd77, 32'd7, 32'd0, 0, 1'b0);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_o_ready", 32'(o_ready), 32'd1);
    chk("midrst_o_valid", 32'(o_valid), 32'd0);
    chk("midrst_o_r",     o_r,          32'h0);

    issue(OP_DIVU, 32'd9, 32'd3, 32'd3, LDIV, 1'b1);
    drain();
    chk("final_queue_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
